// File: rtl/psa_pkg.sv
// Shared definitions for the pattern-search core: default widths and
// the one-hot state encoding used by the search controller.
`timescale 1ns/1ps
package psa_pkg;

    localparam int PSA_DW = 8;
    localparam int PSA_AW = 8;
    localparam int PSA_CW = 9;

    typedef enum logic [4:0] {
        S_IDLE   = 5'b00001,
        S_FETCH  = 5'b00010,
        S_CMP    = 5'b00100,
        S_REPORT = 5'b01000,
        S_DONE   = 5'b10000
    } psa_state_e;

endpackage

// File: rtl/psa_search_core.sv
// Naive sliding-window byte-pattern search over two external 1-cycle BRAMs,
// reporting each match address through a valid/ready handshake.
`timescale 1ns/1ps
module psa_search_core
    import psa_pkg::*;
#(
    parameter int DW = PSA_DW,
    parameter int AW = PSA_AW,
    parameter int CW = PSA_CW
)(
    input  logic          CLK100MHZ,
    input  logic          reset,
    input  logic          start_i,
    input  logic          find_all_i,
    input  logic [AW-1:0] p_base_i,
    input  logic [AW-1:0] p_len_i,
    input  logic [AW-1:0] b_base_i,
    input  logic [AW-1:0] b_len_i,
    output logic [AW-1:0] mem_addr_o,
    input  logic [DW-1:0] mem_data_i,
    output logic [AW-1:0] pat_addr_o,
    input  logic [DW-1:0] pat_data_i,
    output logic          match_valid_o,
    input  logic          match_ready_i,
    output logic [AW-1:0] match_addr_o,
    output logic          busy_o,
    output logic          done_o,
    output logic [CW-1:0] match_count_o
);

    psa_state_e    state_q, state_d;
    logic [AW-1:0] i_q, i_d, j_q, j_d;
    logic [AW-1:0] pBase_q, pBase_d, pLen_q, pLen_d;
    logic [AW-1:0] bBase_q, bBase_d, bLen_q, bLen_d;
    logic          findAll_q, findAll_d;
    logic [CW-1:0] matchCount_q, matchCount_d;
    logic [AW-1:0] matchAddr_q, matchAddr_d;
    logic [AW-1:0] memAddr_q, memAddr_d, patAddr_q, patAddr_d;
    logic          lastWindow;

    // i never exceeds bLen-pLen, so reaching it means no window is left to slide into
    assign lastWindow = (i_q >= (bLen_q - pLen_q));

    always_ff @(posedge CLK100MHZ or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            i_q          <= '0;
            j_q          <= '0;
            pBase_q      <= '0;
            pLen_q       <= '0;
            bBase_q      <= '0;
            bLen_q       <= '0;
            findAll_q    <= 1'b0;
            matchCount_q <= '0;
            matchAddr_q  <= '0;
            memAddr_q    <= '0;
            patAddr_q    <= '0;
        end else begin
            state_q      <= state_d;
            i_q          <= i_d;
            j_q          <= j_d;
            pBase_q      <= pBase_d;
            pLen_q       <= pLen_d;
            bBase_q      <= bBase_d;
            bLen_q       <= bLen_d;
            findAll_q    <= findAll_d;
            matchCount_q <= matchCount_d;
            matchAddr_q  <= matchAddr_d;
            memAddr_q    <= memAddr_d;
            patAddr_q    <= patAddr_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        i_d          = i_q;
        j_d          = j_q;
        pBase_d      = pBase_q;
        pLen_d       = pLen_q;
        bBase_d      = bBase_q;
        bLen_d       = bLen_q;
        findAll_d    = findAll_q;
        matchCount_d = matchCount_q;
        matchAddr_d  = matchAddr_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_i) begin
                    pBase_d      = p_base_i;
                    pLen_d       = p_len_i;
                    bBase_d      = b_base_i;
                    bLen_d       = b_len_i;
                    findAll_d    = find_all_i;
                    i_d          = '0;
                    j_d          = '0;
                    matchCount_d = '0;
                    if ((p_len_i == '0) || (p_len_i > b_len_i)) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_FETCH;
                    end
                end
            end
            S_FETCH: begin
                state_d = S_CMP;
            end
            S_CMP: begin
                if (mem_data_i == pat_data_i) begin
                    if (j_q == (pLen_q - AW'(1))) begin
                        matchAddr_d = bBase_q + i_q;
                        state_d     = S_REPORT;
                    end else begin
                        j_d     = j_q + AW'(1);
                        state_d = S_FETCH;
                    end
                end else begin
                    j_d     = '0;
                    i_d     = i_q + AW'(1);
                    state_d = lastWindow ? S_DONE : S_FETCH;
                end
            end
            S_REPORT: begin
                if (match_ready_i) begin
                    if (matchCount_q != {CW{1'b1}}) begin
                        matchCount_d = matchCount_q + CW'(1);
                    end
                    if (!findAll_q) begin
                        state_d = S_DONE;
                    end else begin
                        j_d     = '0;
                        i_d     = i_q + AW'(1);
                        state_d = lastWindow ? S_DONE : S_FETCH;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Addresses are registered from next-state offsets so they are valid throughout FETCH
        memAddr_d = bBase_d + i_d + j_d;
        patAddr_d = pBase_d + j_d;
    end

    assign mem_addr_o    = memAddr_q;
    assign pat_addr_o    = patAddr_q;
    assign match_valid_o = (state_q == S_REPORT);
    assign match_addr_o  = matchAddr_q;
    assign busy_o        = (state_q == S_FETCH) || (state_q == S_CMP) || (state_q == S_REPORT);
    assign done_o        = (state_q == S_DONE);
    assign match_count_o = matchCount_q;

endmodule
